kahn_topo_sorter: RTL

// - Complete Kahn's-algorithm topological sorter for the graph decoder path. Builds an in-degree

---
 rtl/kahn_pkg.sv | 31 +++
 rtl/zero_indeg_fifo.sv | 55 +++++
 rtl/kahn_topo_sorter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kahn_pkg.sv
// Shared types for the Kahn topological sorter: default sizes, id/in-degree/count
// types, controller states and the opcodes carried by the in-degree RMW pipeline.
package kahn_pkg;

    localparam int DEF_MAX_NODES   = 1024;
    localparam int DEF_MAX_EDGES   = 2048;
    localparam int DEF_NODE_WIDTH  = $clog2(DEF_MAX_NODES);
    localparam int DEF_INDEG_WIDTH = $clog2(DEF_MAX_EDGES) + 1;

    typedef logic [DEF_NODE_WIDTH-1:0]  node_t;
    typedef logic [DEF_INDEG_WIDTH-1:0] indeg_t;
    typedef logic [DEF_NODE_WIDTH:0]    cnt_t;

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        LOAD   = 3'd1,
        SWEEP  = 3'd2,
        POP    = 3'd3,
        EMIT   = 3'd4,
        QUERY  = 3'd5,
        EXPAND = 3'd6,
        DONE   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        RMW_INC  = 2'd0,
        RMW_DEC  = 2'd1,
        RMW_SCAN = 2'd2
    } rmw_op_t;

endpackage

// File: rtl/zero_indeg_fifo.sv
// Work queue of nodes whose in-degree has reached zero. Each node enters at most
// once per sort, so a MAX_NODES-deep queue cannot overflow; head is read combinationally.
module zero_indeg_fifo
    import kahn_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_NODES,
    parameter int W     = DEF_NODE_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         full_s, do_push_s, do_pop_s;

    // Status flags, guarded pointer updates and head read
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        do_push_s = push && !full_s;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        head      = mem[rd_ptr_q[AW-1:0]];
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/kahn_topo_sorter.sv
// Kahn's-algorithm topological sorter: builds an in-degree table from streamed edges,
// sweeps for roots, then pops/emits/expands nodes until the work queue drains.
module kahn_topo_sorter
    import kahn_pkg::*;
#(
    parameter int MAX_NODES   = DEF_MAX_NODES,
    parameter int MAX_EDGES   = DEF_MAX_EDGES,
    parameter int NODE_WIDTH  = $clog2(MAX_NODES),
    parameter int INDEG_WIDTH = $clog2(MAX_EDGES) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  edge_ready,
    input  logic                  edge_valid,
    input  logic [NODE_WIDTH-1:0] src_node,
    input  logic [NODE_WIDTH-1:0] dst_node,
    input  logic                  decoding_done,
    input  logic [NODE_WIDTH:0]   node_count,
    output logic                  query_valid,
    input  logic                  query_ready,
    output logic [NODE_WIDTH-1:0] query_data,
    input  logic                  reply_valid,
    output logic                  reply_ready,
    input  logic [NODE_WIDTH-1:0] reply_data,
    input  logic                  reply_none,
    input  logic                  reply_last,
    output logic                  sorted_valid,
    input  logic                  sorted_ready,
    output logic [NODE_WIDTH-1:0] sorted_node,
    output logic [NODE_WIDTH:0]   sorted_cnt,
    output logic                  done,
    output logic                  cycle_detected
);

    localparam logic [NODE_WIDTH-1:0]  LAST_ID    = NODE_WIDTH'(MAX_NODES - 1);
    localparam logic [NODE_WIDTH-1:0]  NODE_ONE   = NODE_WIDTH'(1);
    localparam logic [NODE_WIDTH:0]    CNT_ZERO   = (NODE_WIDTH+1)'(0);
    localparam logic [NODE_WIDTH:0]    CNT_ONE    = (NODE_WIDTH+1)'(1);
    localparam logic [INDEG_WIDTH-1:0] INDEG_ZERO = INDEG_WIDTH'(0);
    localparam logic [INDEG_WIDTH-1:0] INDEG_ONE  = INDEG_WIDTH'(1);
    localparam logic [INDEG_WIDTH-1:0] INDEG_MAX  = {INDEG_WIDTH{1'b1}};

    state_t                  state_q, state_d;
    logic [NODE_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic                    dd_pend_q, dd_pend_d;
    logic [NODE_WIDTH:0]     ncount_q, ncount_d;
    logic [NODE_WIDTH:0]     scan_idx_q, scan_idx_d;
    logic [NODE_WIDTH-1:0]   cur_node_q, cur_node_d;
    logic [NODE_WIDTH:0]     sorted_cnt_q, sorted_cnt_d;
    logic                    last_seen_q, last_seen_d;
    logic                    done_q, done_d;
    logic                    cycle_q, cycle_d;
    logic                    edge_ready_q, edge_ready_d;
    logic                    sorted_valid_q, sorted_valid_d;
    logic                    query_valid_q, query_valid_d;
    logic                    reply_ready_q, reply_ready_d;

    logic                    s1_valid_q, s1_valid_d;
    rmw_op_t                 s1_op_q, s1_op_d;
    logic [NODE_WIDTH-1:0]   s1_addr_q, s1_addr_d;
    logic                    lw_valid_q, lw_valid_d;
    logic [NODE_WIDTH-1:0]   lw_addr_q, lw_addr_d;
    logic [INDEG_WIDTH-1:0]  lw_data_q, lw_data_d;

    logic [INDEG_WIDTH-1:0]  indeg_mem [MAX_NODES];
    logic [INDEG_WIDTH-1:0]  rd_data_q;
    logic [NODE_WIDTH-1:0]   rd_addr_s, wr_addr_s;
    logic [INDEG_WIDTH-1:0]  wr_data_s, base_s;
    logic                    wr_en_s, push_s, pop_s, edge_fire_s, beat_fire_s;
    logic [NODE_WIDTH-1:0]   fifo_head_s;
    logic                    fifo_empty_s;
    logic                    src_unused_s;

    // The edge source carries no information for in-degree counting.
    assign src_unused_s = ^src_node;

    assign edge_ready     = edge_ready_q;
    assign query_valid    = query_valid_q;
    assign query_data     = cur_node_q;
    assign reply_ready    = reply_ready_q;
    assign sorted_valid   = sorted_valid_q;
    assign sorted_node    = cur_node_q;
    assign sorted_cnt     = sorted_cnt_q;
    assign done           = done_q;
    assign cycle_detected = cycle_q;

    zero_indeg_fifo #(
        .DEPTH (MAX_NODES),
        .W     (NODE_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (s1_addr_q),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s)
    );

    // In-degree table: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            indeg_mem[wr_addr_s] <= wr_data_s;
        end
        rd_data_q <= indeg_mem[rd_addr_s];
    end

    // Controller next-state, RMW pipeline and output decode
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        dd_pend_d    = dd_pend_q;
        ncount_d     = ncount_q;
        scan_idx_d   = scan_idx_q;
        cur_node_d   = cur_node_q;
        sorted_cnt_d = sorted_cnt_q;
        last_seen_d  = last_seen_q;
        done_d       = done_q;
        cycle_d      = cycle_q;
        s1_valid_d   = 1'b0;
        s1_op_d      = s1_op_q;
        s1_addr_d    = s1_addr_q;
        lw_valid_d   = lw_valid_q;
        lw_addr_d    = lw_addr_q;
        lw_data_d    = lw_data_q;
        rd_addr_s    = s1_addr_q;
        wr_en_s      = 1'b0;
        wr_addr_s    = s1_addr_q;
        wr_data_s    = INDEG_ZERO;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        edge_fire_s  = edge_valid && edge_ready_q;
        beat_fire_s  = reply_valid && reply_ready_q;
        // The write retired on the previous edge is not yet visible in rd_data_q.
        base_s       = (lw_valid_q && (lw_addr_q == s1_addr_q)) ? lw_data_q : rd_data_q;

        if (s1_valid_q) begin
            case (s1_op_q)
                RMW_INC: begin
                    wr_en_s   = 1'b1;
                    wr_data_s = (base_s == INDEG_MAX) ? INDEG_MAX : (base_s + INDEG_ONE);
                end
                RMW_DEC: begin
                    if (base_s == INDEG_ZERO) begin
                        cycle_d = 1'b1;
                    end else begin
                        wr_en_s   = 1'b1;
                        wr_data_s = base_s - INDEG_ONE;
                        push_s    = (base_s == INDEG_ONE);
                    end
                end
                RMW_SCAN: push_s  = (base_s == INDEG_ZERO);
                default:  cycle_d = cycle_q;
            endcase
        end else begin
            wr_en_s = 1'b0;
        end

        if (wr_en_s) begin
            lw_valid_d = 1'b1;
            lw_addr_d  = wr_addr_s;
            lw_data_d  = wr_data_s;
        end else begin
            lw_valid_d = lw_valid_q;
        end

        case (state_q)
            CLEAR: begin
                wr_en_s    = 1'b1;
                wr_addr_s  = clr_idx_q;
                wr_data_s  = INDEG_ZERO;
                lw_valid_d = 1'b0;
                clr_idx_d  = clr_idx_q + NODE_ONE;
                if (decoding_done) begin
                    dd_pend_d = 1'b1;
                    ncount_d  = node_count;
                end else begin
                    dd_pend_d = dd_pend_q;
                end
                state_d = (clr_idx_q == LAST_ID) ? LOAD : CLEAR;
            end
            LOAD: begin
                if (edge_fire_s) begin
                    rd_addr_s  = dst_node;
                    s1_valid_d = 1'b1;
                    s1_op_d    = RMW_INC;
                    s1_addr_d  = dst_node;
                end else begin
                    s1_valid_d = 1'b0;
                end
                if (decoding_done || dd_pend_q) begin
                    dd_pend_d  = 1'b0;
                    ncount_d   = decoding_done ? node_count : ncount_q;
                    scan_idx_d = CNT_ZERO;
                    if (ncount_d == CNT_ZERO) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SWEEP;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            SWEEP: begin
                if (scan_idx_q < ncount_q) begin
                    rd_addr_s  = scan_idx_q[NODE_WIDTH-1:0];
                    s1_valid_d = 1'b1;
                    s1_op_d    = RMW_SCAN;
                    s1_addr_d  = scan_idx_q[NODE_WIDTH-1:0];
                    scan_idx_d = scan_idx_q + CNT_ONE;
                end else if (!s1_valid_q) begin
                    state_d = POP;
                end else begin
                    state_d = SWEEP;
                end
            end
            POP: begin
                if (fifo_empty_s) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cycle_d = cycle_q || (sorted_cnt_q != ncount_q);
                end else begin
                    pop_s      = 1'b1;
                    cur_node_d = fifo_head_s;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (sorted_valid_q && sorted_ready) begin
                    sorted_cnt_d = sorted_cnt_q + CNT_ONE;
                    state_d      = QUERY;
                end else begin
                    state_d = EMIT;
                end
            end
            QUERY: begin
                if (query_valid_q && query_ready) begin
                    last_seen_d = 1'b0;
                    state_d     = EXPAND;
                end else begin
                    state_d = QUERY;
                end
            end
            EXPAND: begin
                if (beat_fire_s && !reply_none) begin
                    rd_addr_s  = reply_data;
                    s1_valid_d = 1'b1;
                    s1_op_d    = RMW_DEC;
                    s1_addr_d  = reply_data;
                end else begin
                    s1_valid_d = 1'b0;
                end
                last_seen_d = last_seen_q || (beat_fire_s && reply_last);
                // Leave only after the final decrement has been written back.
                state_d = (last_seen_q && !s1_valid_q) ? POP : EXPAND;
            end
            DONE:    state_d = DONE;
            default: state_d = CLEAR;
        endcase

        edge_ready_d   = (state_d == LOAD);
        sorted_valid_d = (state_d == EMIT);
        query_valid_d  = (state_d == QUERY);
        reply_ready_d  = (state_d == EXPAND) && !last_seen_d;
    end

    // Controller, pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CLEAR;
            clr_idx_q      <= '0;
            dd_pend_q      <= 1'b0;
            ncount_q       <= '0;
            scan_idx_q     <= '0;
            cur_node_q     <= '0;
            sorted_cnt_q   <= '0;
            last_seen_q    <= 1'b0;
            done_q         <= 1'b0;
            cycle_q        <= 1'b0;
            edge_ready_q   <= 1'b0;
            sorted_valid_q <= 1'b0;
            query_valid_q  <= 1'b0;
            reply_ready_q  <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_op_q        <= RMW_INC;
            s1_addr_q      <= '0;
            lw_valid_q     <= 1'b0;
            lw_addr_q      <= '0;
            lw_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            dd_pend_q      <= dd_pend_d;
            ncount_q       <= ncount_d;
            scan_idx_q     <= scan_idx_d;
            cur_node_q     <= cur_node_d;
            sorted_cnt_q   <= sorted_cnt_d;
            last_seen_q    <= last_seen_d;
            done_q         <= done_d;
            cycle_q        <= cycle_d;
            edge_ready_q   <= edge_ready_d;
            sorted_valid_q <= sorted_valid_d;
            query_valid_q  <= query_valid_d;
            reply_ready_q  <= reply_ready_d;
            s1_valid_q     <= s1_valid_d;
            s1_op_q        <= s1_op_d;
            s1_addr_q      <= s1_addr_d;
            lw_valid_q     <= lw_valid_d;
            lw_addr_q      <= lw_addr_d;
            lw_data_q      <= lw_data_d;
        end
    end

endmodule
